// File: rtl/rdid_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rdid_spi_ctrl
// Purpose : SPI mode-0 master. It sends the RDID command (0x9F) to an M25P16
//           serial PROM and captures the 3-byte JEDEC ID.
// Option  : define RDID_CHECK_EN to compare the manufacturer ID with
//           EXPECT_MAN_ID. On a mismatch, id_error is raised and valid is
//           cleared.
// Rev     : 1.0  initial release
// ============================================================================
module rdid_spi_ctrl #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CS_GAP        = 5,
  parameter logic [7:0]  EXPECT_MAN_ID = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       spi_miso,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] man_id,
  output logic [7:0] mem_type,
  output logic [7:0] mem_cap,
  output logic       valid,
  output logic       id_error
);

  localparam logic [7:0]       RDID_CMD = 8'h9F;
  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned      GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [4:0]       bit_q, bit_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [23:0]      rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             csn_q, csn_d;
  logic             done_q, done_d;
  logic [7:0]       man_q, man_d;
  logic [7:0]       type_q, type_d;
  logic [7:0]       cap_q, cap_d;
  logic             valid_q, valid_d;
`ifdef RDID_CHECK_EN
  logic             err_q, err_d;
`endif

  // State and output registers; every SPI pin comes straight from a flop, so the pins cannot glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      cmd_q   <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      done_q  <= 1'b0;
      man_q   <= '0;
      type_q  <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
`ifdef RDID_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      done_q  <= done_d;
      man_q   <= man_d;
      type_q  <= type_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
`ifdef RDID_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: phase timing, command shift-out, response shift-in, ID commit
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    done_d  = 1'b0;
    man_d   = man_q;
    type_d  = type_q;
    cap_d   = cap_q;
    valid_d = valid_q;
`ifdef RDID_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          csn_d   = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = RDID_CMD[7];
          cmd_d   = {RDID_CMD[6:0], 1'b0};
          div_d   = '0;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            // The rising edge samples MISO. The 8 command-phase bits are
            // shifted out of the top, so 24 response bits remain.
            sclk_d = 1'b1;
            rx_d   = {rx_q[22:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 5'd31) begin
              state_d = ST_HOLD;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_q + 5'd1;
              mosi_d = cmd_q[7];
              cmd_d  = {cmd_q[6:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_GAP;
          csn_d   = 1'b1;
          done_d  = 1'b1;
          gap_d   = '0;
          man_d   = rx_q[23:16];
          type_d  = rx_q[15:8];
          cap_d   = rx_q[7:0];
`ifdef RDID_CHECK_EN
          err_d   = (rx_q[23:16] != EXPECT_MAN_ID);
          valid_d = (rx_q[23:16] == EXPECT_MAN_ID);
`else
          valid_d = 1'b1;
`endif
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign cs_n     = csn_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign man_id   = man_q;
  assign mem_type = type_q;
  assign mem_cap  = cap_q;
  assign valid    = valid_q;
`ifdef RDID_CHECK_EN
  assign id_error = err_q;
`else
  // Without the check, id_error is constant 0. The expression still names
  // EXPECT_MAN_ID so that the parameter is not left dangling in this build.
  assign id_error = (EXPECT_MAN_ID == EXPECT_MAN_ID) ? 1'b0 : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rdid_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rdid_spi_ctrl
// Purpose : Directed bench for rdid_spi_ctrl. It contains a simple M25P16
//           RDID responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rdid_spi_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       spi_miso = 1'b0;
  logic       spi_clk, spi_mosi, cs_n, busy, done, valid, id_error;
  logic [7:0] man_id, mem_type, mem_cap;

  int total = 0;
  int bad   = 0;

  rdid_spi_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .spi_miso (spi_miso),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .cs_n     (cs_n),
    .busy     (busy),
    .done     (done),
    .man_id   (man_id),
    .mem_type (mem_type),
    .mem_cap  (mem_cap),
    .valid    (valid),
    .id_error (id_error)
  );

  always #10 clk = ~clk;

  // PROM responder: captures the command on rising spi_clk edges and, after
  // RDID, shifts the ID out on falling edges.
  logic [23:0] model_id = 24'h202015;
  logic [23:0] m_sh     = 24'h0;
  logic [7:0]  m_cmd    = 8'h0;
  int          m_rise   = 0;
  logic        m_prev   = 1'b0;

  always @(negedge clk) begin
    if (cs_n !== 1'b0) begin
      m_rise   = 0;
      m_cmd    = 8'h0;
      m_sh     = model_id;
      m_prev   = 1'b0;
      spi_miso = 1'b0;
    end else begin
      if (spi_clk && !m_prev) begin
        if (m_rise < 8) m_cmd = {m_cmd[6:0], spi_mosi};
        m_rise++;
      end else if (!spi_clk && m_prev && m_rise >= 8 && m_cmd == 8'h9F) begin
        spi_miso = m_sh[23];
        m_sh     = {m_sh[22:0], 1'b0};
      end
      m_prev = spi_clk;
    end
  end

  task automatic test_reset();
    int idle_bad = 0;
    int done_seen = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL reset_spi_clk got=%b want=0", spi_clk); end
    total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", spi_mosi); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    total++; if ({man_id, mem_type, mem_cap} !== 24'h0) begin bad++; $display("FAIL reset_ids got=%h want=000000", {man_id, mem_type, mem_cap}); end
    total++; if (valid !== 1'b0 || id_error !== 1'b0) begin bad++; $display("FAIL reset_valid_err got=%b%b want=00", valid, id_error); end
    repeat (200) begin
      @(posedge clk); #1;
      if (cs_n !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0) idle_bad++;
      if (done !== 1'b0) done_seen++;
    end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL idle_pins got=%0d bad cycles want=0", idle_bad); end
    total++; if (done_seen != 0) begin bad++; $display("FAIL idle_done got=%0d pulses want=0", done_seen); end
    total++; if ({man_id, mem_type, mem_cap, valid} !== 25'h0) begin bad++; $display("FAIL idle_ids got=%h valid=%b want=000000/0", {man_id, mem_type, mem_cap}, valid); end
  endtask

  // One full RDID transaction. Checks latency, pin activity, captured ID and
  // that the previous ID stays in place until done.
  task automatic test_rdid(input logic [23:0] id, input logic [23:0] prev_ids, input logic prev_valid);
    int          cyc = 1;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          cs_low = 0;
    int          rises = 0;
    int          busy_fall = 0;
    int          hold_bad = 0;
    logic [31:0] mosi_bits = 32'h0;
    logic        prev_clk = 1'b0;
    logic        exp_valid;
    logic        exp_err;
`ifdef RDID_CHECK_EN
    exp_valid = (id[23:16] == 8'h20);
    exp_err   = (id[23:16] != 8'h20);
`else
    exp_valid = 1'b1;
    exp_err   = 1'b0;
`endif
    model_id = id;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total++; if ({cs_n, busy, spi_mosi, spi_clk} !== 4'b0110) begin bad++; $display("FAIL txn_cycle1 cs_n,busy,mosi,sclk got=%b want=0110", {cs_n, busy, spi_mosi, spi_clk}); end
    while (cyc < 400 && busy_fall == 0) begin
      if (cs_n === 1'b0) cs_low++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt == 0 && ({man_id, mem_type, mem_cap} !== prev_ids || valid !== prev_valid)) hold_bad++;
      if (spi_clk === 1'b1 && !prev_clk) begin mosi_bits = {mosi_bits[30:0], spi_mosi}; rises++; end
      prev_clk = spi_clk;
      if (busy === 1'b0) busy_fall = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (done_cyc != 131 || done_cnt != 1) begin bad++; $display("FAIL txn_done cycle=%0d count=%0d want 131/1", done_cyc, done_cnt); end
    total++; if (cs_low != 130) begin bad++; $display("FAIL txn_cs_low got=%0d want=130", cs_low); end
    total++; if (rises != 32) begin bad++; $display("FAIL txn_sclk_rises got=%0d want=32", rises); end
    total++; if (mosi_bits !== 32'h9F00_0000) begin bad++; $display("FAIL txn_mosi got=%h want=9f000000", mosi_bits); end
    total++; if (busy_fall != 136) begin bad++; $display("FAIL txn_busy_fall got=%0d want=136", busy_fall); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL txn_prev_hold got=%0d bad cycles want=0", hold_bad); end
    total++; if ({man_id, mem_type, mem_cap} !== id) begin bad++; $display("FAIL txn_ids got=%h want=%h", {man_id, mem_type, mem_cap}, id); end
    total++; if (valid !== exp_valid || id_error !== exp_err) begin bad++; $display("FAIL txn_valid_err got=%b%b want=%b%b", valid, id_error, exp_valid, exp_err); end
  endtask

  task automatic test_reset_mid();
    int cyc = 1;
    int done_seen = 0;
    int cs_bad = 0;
    model_id = 24'h202015;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (cs_n !== 1'b0) begin bad++; $display("FAIL mid_active got cs_n=%b want=0", cs_n); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({cs_n, spi_clk, spi_mosi, busy, done} !== 5'b10000) begin bad++; $display("FAIL mid_reset_pins got=%b want=10000", {cs_n, spi_clk, spi_mosi, busy, done}); end
    total++; if ({man_id, mem_type, mem_cap, valid} !== 25'h0) begin bad++; $display("FAIL mid_reset_ids got=%h valid=%b want=000000/0", {man_id, mem_type, mem_cap}, valid); end
    reset = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen++;
      if (cs_n !== 1'b1) cs_bad++;
    end
    total++; if (done_seen != 0 || cs_bad != 0) begin bad++; $display("FAIL mid_after got done=%0d cs_low=%0d want=0/0", done_seen, cs_bad); end
  endtask

  // start held high for the whole busy window, including the last GAP cycle
  task automatic test_back_to_back();
    int   cyc = 1;
    int   cs_falls = 1;
    int   done_cnt = 0;
    int   idle_bad = 0;
    logic prev_cs = 1'b0;
    model_id = 24'h202015;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    while (cyc < 400 && busy === 1'b1) begin
      if (prev_cs === 1'b1 && cs_n === 1'b0) cs_falls++;
      if (done === 1'b1) done_cnt++;
      prev_cs = cs_n;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    total++; if (cyc != 136) begin bad++; $display("FAIL b2b_busy_len got=%0d want=136", cyc); end
    total++; if (cs_falls != 1 || done_cnt != 1) begin bad++; $display("FAIL b2b_single got falls=%0d dones=%0d want=1/1", cs_falls, done_cnt); end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL b2b_no_requeue got=%0d bad cycles want=0", idle_bad); end
    total++; if ({man_id, mem_type, mem_cap} !== 24'h202015) begin bad++; $display("FAIL b2b_ids got=%h want=202015", {man_id, mem_type, mem_cap}); end
  endtask

  initial begin
    test_reset();
    test_rdid(24'h202015, 24'h000000, 1'b0);
    test_reset_mid();
    test_back_to_back();
    test_rdid(24'h202015, 24'h202015, 1'b1);
    test_rdid(24'hA53C81, 24'h202015, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
